// File: rtl/onehot_index_driver_if.sv
// ----------------------------------------------------------------------------
// onehot_index_driver_if
//   Bundles the control inputs and status outputs of onehot_index_driver.
//   The master side (ALU control path) drives the position and mode.
//   The slave side (the driver) returns the one-hot pattern and status.
//
//   Index     master->slave  IDX_W  binary position to load
//   Load      master->slave  1      one-cycle load strobe
//   Scan      master->slave  1      0 = static hold, 1 = auto-rotate
//   Dir       master->slave  1      0 = rotate toward MSB, 1 = toward LSB
//   OneHot    slave->master  WIDTH  registered one-hot (or all-zero) pattern
//   CurIndex  slave->master  IDX_W  binary index of the hot bit, 0 when idle
//   Error     slave->master  1      sticky out-of-range load flag
//   Step      slave->master  1      one-cycle pulse per scan rotation
// ----------------------------------------------------------------------------
interface onehot_index_driver_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
);
    logic [IDX_W-1:0] Index;
    logic             Load;
    logic             Scan;
    logic             Dir;
    logic [WIDTH-1:0] OneHot;
    logic [IDX_W-1:0] CurIndex;
    logic             Error;
    logic             Step;

    modport master (
        output Index,
        output Load,
        output Scan,
        output Dir,
        input  OneHot,
        input  CurIndex,
        input  Error,
        input  Step
    );

    modport slave (
        input  Index,
        input  Load,
        input  Scan,
        input  Dir,
        output OneHot,
        output CurIndex,
        output Error,
        output Step
    );
endinterface

// File: rtl/onehot_index_driver.sv
// ----------------------------------------------------------------------------
// onehot_index_driver
//   Drives a WIDTH-bit one-hot LED pattern from a binary index. In static
//   mode the loaded position is held; in scan mode the hot bit rotates one
//   place every DIV clock cycles. The current position is reported back as
//   a binary index and out-of-range loads raise a sticky error flag.
//
//   Clock   in   rising-edge clock
//   ResetN  in   asynchronous active-low reset
//   io      slave side of onehot_index_driver_if
//             Index/Load/Scan/Dir in, OneHot/CurIndex/Error/Step out
//   All outputs are registered; none is combinational from an input.
// ----------------------------------------------------------------------------
module onehot_index_driver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned DIV   = 1000
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    onehot_index_driver_if.slave  io
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    TERM_CNT = PW'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    // One extra bit so the range check also works when IDX_W can just hold WIDTH.
    localparam logic [IDX_W:0]   WIDTH_X  = (IDX_W + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] one_hot_q, one_hot_d;
    logic [IDX_W-1:0] cur_q,     cur_d;
    logic             error_q,   error_d;
    logic             step_q,    step_d;
    logic [PW-1:0]    presc_q,   presc_d;

    logic             index_ok;

    assign index_ok = ({1'b0, io.Index} < WIDTH_X);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            one_hot_q <= '0;
            cur_q     <= '0;
            error_q   <= 1'b0;
            step_q    <= 1'b0;
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            one_hot_q <= one_hot_d;
            cur_q     <= cur_d;
            error_q   <= error_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        one_hot_d = one_hot_q;
        cur_d     = cur_q;
        error_d   = error_q;
        step_d    = 1'b0;
        presc_d   = presc_q;

        if (io.Load) begin
            // A load always wins over a coincident terminal count.
            presc_d = '0;
            if (index_ok) begin
                one_hot_d = WIDTH'(1) << io.Index;
                cur_d     = io.Index;
                error_d   = 1'b0;
                state_d   = io.Scan ? SCAN : HOLD;
            end else begin
                one_hot_d = '0;
                cur_d     = '0;
                error_d   = 1'b1;
                state_d   = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                end

                HOLD: begin
                    // Entering SCAN starts the count from 0, so the first
                    // rotation lands a full DIV cycles after the switch.
                    presc_d = '0;
                    if (io.Scan) begin
                        state_d = SCAN;
                    end
                end

                SCAN: begin
                    if (!io.Scan) begin
                        state_d = HOLD;
                        presc_d = '0;
                    end else if (presc_q == TERM_CNT) begin
                        presc_d = '0;
                        step_d  = 1'b1;
                        if (io.Dir) begin
                            one_hot_d = {one_hot_q[0], one_hot_q[WIDTH-1:1]};
                            cur_d     = (cur_q == '0) ? LAST_IDX : cur_q - IDX_W'(1);
                        end else begin
                            one_hot_d = {one_hot_q[WIDTH-2:0], one_hot_q[WIDTH-1]};
                            cur_d     = (cur_q == LAST_IDX) ? '0 : cur_q + IDX_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end

                default: begin
                    state_d   = IDLE;
                    one_hot_d = '0;
                    cur_d     = '0;
                    presc_d   = '0;
                end
            endcase
        end
    end

    assign io.OneHot   = one_hot_q;
    assign io.CurIndex = cur_q;
    assign io.Error    = error_q;
    assign io.Step     = step_q;

    // At most one hot bit, and never unknown, at every edge out of reset.
    a_onehot0 : assert property (@(posedge Clock) disable iff (!ResetN)
        $onehot0(one_hot_q) && !$isunknown(one_hot_q));

endmodule

// File: tb/tb_onehot_index_driver.sv
// ----------------------------------------------------------------------------
// tb_onehot_index_driver
//   Directed scenarios followed by randomized traffic. A behavioural model
//   tracks the hot position as an integer and queues the expected outputs
//   after every edge; a monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_onehot_index_driver;

    localparam int unsigned W   = 8;
    localparam int unsigned IW  = 4;
    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [W-1:0]  oh;
        logic [IW-1:0] ci;
        logic          err;
        logic          step;
    } exp_t;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;

    onehot_index_driver_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    onehot_index_driver #(.WIDTH(W), .IDX_W(IW), .DIV(DIV)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .io     (bus)
    );

    always #5 Clock = ~Clock;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model state
    int m_pos     = 0;
    bit m_active  = 1'b0;
    bit m_scan    = 1'b0;
    bit m_err     = 1'b0;
    bit m_step    = 1'b0;
    int m_cnt     = 0;

    function automatic exp_t model_out();
        exp_t e;
        e.oh   = m_active ? (W'(1) << m_pos) : '0;
        e.ci   = IW'(m_pos);
        e.err  = m_err;
        e.step = m_step;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: one update per edge, or immediately on reset.
    initial begin
        forever begin
            @(posedge Clock or negedge ResetN);
            if (!ResetN) begin
                m_active = 1'b0;
                m_scan   = 1'b0;
                m_pos    = 0;
                m_err    = 1'b0;
                m_step   = 1'b0;
                m_cnt    = 0;
                exp_q.delete();
                exp_q.push_back(model_out());
            end else begin
                m_step = 1'b0;
                if (bus.Load) begin
                    m_cnt = 0;
                    if (int'(bus.Index) < W) begin
                        m_pos    = int'(bus.Index);
                        m_active = 1'b1;
                        m_scan   = bus.Scan;
                        m_err    = 1'b0;
                    end else begin
                        m_pos    = 0;
                        m_active = 1'b0;
                        m_scan   = 1'b0;
                        m_err    = 1'b1;
                    end
                end else if (m_active) begin
                    if (!bus.Scan) begin
                        m_scan = 1'b0;
                        m_cnt  = 0;
                    end else if (!m_scan) begin
                        m_scan = 1'b1;
                        m_cnt  = 0;
                    end else if (m_cnt == DIV - 1) begin
                        m_pos  = (m_pos + (bus.Dir ? W - 1 : 1)) % W;
                        m_step = 1'b1;
                        m_cnt  = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                exp_q.push_back(model_out());
            end
        end
    end

    // Monitor: compare DUT outputs to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("onehot",   int'(bus.OneHot),   int'(e.oh));
                check("curindex", int'(bus.CurIndex), int'(e.ci));
                check("error",    int'(bus.Error),    int'(e.err));
                check("step",     int'(bus.Step),     int'(e.step));
            end
        end
    end

    // Asynchronous reset must clear the outputs without waiting for a clock.
    initial begin
        forever begin
            @(negedge ResetN);
            #1;
            check("rst_onehot",   int'(bus.OneHot),   0);
            check("rst_curindex", int'(bus.CurIndex), 0);
            check("rst_error",    int'(bus.Error),    0);
            check("rst_step",     int'(bus.Step),     0);
        end
    end

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [IW-1:0] idx, input logic scan, input logic dir);
        bus.Index = idx;
        bus.Scan  = scan;
        bus.Dir   = dir;
        bus.Load  = 1'b1;
        cycle(1);
        bus.Load  = 1'b0;
    endtask

    initial begin
        bus.Index = '0;
        bus.Load  = 1'b0;
        bus.Scan  = 1'b0;
        bus.Dir   = 1'b0;
        ResetN    = 1'b0;
        cycle(3);
        ResetN = 1'b1;
        cycle(2);

        // Static hold
        do_load(4'd5, 1'b0, 1'b0);
        cycle(20);

        // Out-of-range load, then recovery
        do_load(4'd9, 1'b0, 1'b0);
        cycle(3);
        do_load(4'd2, 1'b0, 1'b0);
        cycle(3);

        // Scan toward MSB with wrap 7 -> 0
        do_load(4'd6, 1'b1, 1'b0);
        cycle(10);

        // Scan toward LSB with wrap 0 -> 7
        do_load(4'd0, 1'b1, 1'b1);
        cycle(10);

        // Load coinciding with the terminal count
        do_load(4'd6, 1'b1, 1'b0);
        cycle(DIV - 1);
        do_load(4'd3, 1'b1, 1'b0);
        cycle(10);

        // Scan off then on again, direction flip mid-scan
        bus.Scan = 1'b0;
        cycle(5);
        bus.Scan = 1'b1;
        cycle(6);
        bus.Dir = 1'b1;
        cycle(9);

        // Reset asynchronously mid-scan; stay idle with Scan=1 until a load
        @(posedge Clock);
        #3;
        ResetN = 1'b0;
        cycle(2);
        @(posedge Clock);
        #3;
        ResetN = 1'b1;
        cycle(8);
        do_load(4'd1, 1'b1, 1'b0);
        cycle(10);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.Load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.Index = IW'($urandom_range(8, 15));
            else
                bus.Index = IW'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) bus.Scan = ~bus.Scan;
            if ($urandom_range(0, 9) == 0)  bus.Dir  = ~bus.Dir;
            cycle(1);
        end
        bus.Load = 1'b0;
        cycle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
